// File: rtl/ram_readback_checker_if.sv
// RAM read-port bundle between the readback checker (master) and the RAM (slave).
interface ram_readback_checker_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // rd_en is the valid for rd_addr; there is no ready, the RAM accepts every
  // read, and q carries that word a fixed RD_LAT cycles later.
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] q;

  modport master (output rd_addr, output rd_en, input q);
  modport slave  (input rd_addr, input rd_en, output q);
endinterface

// File: rtl/ram_readback_checker.sv
// Sweeps every RAM address once, compares q against (addr + OFFSET) and reports
// pass, a saturating mismatch count and the first failing address.
module ram_readback_checker #(
  parameter int                ADDR_W = 8,
  parameter int                DATA_W = 8,
  parameter int                RD_LAT = 1,
  parameter logic [DATA_W-1:0] OFFSET = '0,
  parameter int                CNT_W  = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  ram_readback_checker_if.master ram,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [ADDR_W-1:0]      first_err_addr,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  state_t            state, state_nxt;
  logic              sweep_go;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        drain_cnt;
  logic              first_seen;

  logic              pipe_vld  [RD_LAT];
  logic [ADDR_W-1:0] pipe_addr [RD_LAT];
  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] exp_val;
  logic              mismatch;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sweep_go  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = READ;
          sweep_go  = 1'b1;
        end
      end
      READ:    if (rd_addr == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_en       = (state == READ);
  assign busy        = (state == READ) || (state == DRAIN);
  assign done        = (state == DONE);
  assign pass        = done && (err_cnt == '0);
  assign state_dbg   = state;
  assign ram.rd_en   = rd_en;
  assign ram.rd_addr = rd_addr;

  // The address parks on the top word after READ; it is only reloaded by a new sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr   <= '0;
      drain_cnt <= '0;
    end else begin
      if (sweep_go)
        rd_addr <= '0;
      else if (rd_en && (rd_addr != LAST_ADDR))
        rd_addr <= rd_addr + 1'b1;
      if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                drain_cnt <= '0;
    end
  end

  // Delay line matching the RAM latency so each q lines up with its own address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= rd_en;
      pipe_addr[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  assign cmp_vld  = pipe_vld[RD_LAT-1];
  assign cmp_addr = pipe_addr[RD_LAT-1];
  assign exp_val  = DATA_W'(cmp_addr) + OFFSET;
  assign mismatch = cmp_vld && (ram.q != exp_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_seen     <= 1'b0;
    end else if (sweep_go) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_seen     <= 1'b0;
    end else if (mismatch) begin
      if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
      if (!first_seen) begin
        first_err_addr <= cmp_addr;
        first_seen     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_readback_checker.sv
// Bench for ram_readback_checker: a default instance and a RD_LAT=2/OFFSET=0x10/CNT_W=4
// instance run side by side, each against its own RAM model and result scoreboard.
module tb_ram_readback_checker;

  localparam int EW = 19;  // {chk_cnt, pass, err_cnt[8:0], first_err_addr[7:0]}

  logic       clk;
  logic       rst;
  logic       start;

  ram_readback_checker_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
  ram_readback_checker_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [8:0] err_cnt0;
  logic [3:0] err_cnt1;
  logic [7:0] first0, first1;
  logic [1:0] st0, st1;

  logic [7:0] mem [2][256];
  int         ram_dly [2];
  int         lat_cfg [2];
  logic [7:0] r0_s1, r0_s2, r1_s1, r1_s2;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];

  int          checks;
  int          failures;
  int unsigned busy_len [2];
  int unsigned addr_bad [2];
  int unsigned addr_exp [2];
  logic        prev_busy [2];
  logic        prev_done [2];

  ram_readback_checker dut0 (
    .clk(clk), .rst(rst), .start(start), .ram(bus0.master),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err_cnt0),
    .first_err_addr(first0), .state_dbg(st0)
  );

  ram_readback_checker #(.RD_LAT(2), .OFFSET(8'h10), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .ram(bus1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
    .first_err_addr(first1), .state_dbg(st1)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM models (registered read, 1 or 2 cycles) ----------------
  always @(posedge clk) begin
    r0_s1 <= mem[0][bus0.rd_addr];
    r0_s2 <= r0_s1;
    r1_s1 <= mem[1][bus1.rd_addr];
    r1_s2 <= r1_s1;
  end
  assign bus0.q = (ram_dly[0] == 2) ? r0_s2 : r0_s1;
  assign bus1.q = (ram_dly[1] == 2) ? r1_s2 : r1_s1;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: count words whose stored value differs from (a + offset) mod 256.
  task automatic push_expect();
    int         off, cmax, cnt, first;
    bit         seen, lat_ok;
    logic [EW-1:0] e;
    for (int g = 0; g < 2; g++) begin
      off    = (g == 0) ? 0 : 16;
      cmax   = (g == 0) ? 511 : 15;
      cnt    = 0;
      first  = 0;
      seen   = 1'b0;
      lat_ok = (ram_dly[g] == lat_cfg[g]);
      for (int a = 0; a < 256; a++) begin
        if (mem[g][a] != 8'((a + off) % 256)) begin
          cnt++;
          if (!seen) begin
            first = a;
            seen  = 1'b1;
          end
        end
      end
      e = {lat_ok, (cnt == 0) && lat_ok, 9'((cnt > cmax) ? cmax : cnt), 8'(first)};
      if (g == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
  endtask

  task automatic mon_step(input int g, input logic b, input logic d, input logic en,
                          input logic [7:0] ad, input logic p, input logic [8:0] ec,
                          input logic [7:0] fa);
    logic [EW-1:0] e;
    string         tag;
    int            qsz;
    tag = (g == 0) ? "lat1" : "lat2";
    if (rst) begin
      if (g == 0) exp_q0.delete();
      else        exp_q1.delete();
      prev_busy[g] = 1'b0;
      prev_done[g] = 1'b0;
      return;
    end
    if (b && !prev_busy[g]) begin
      busy_len[g] = 0;
      addr_bad[g] = 0;
      addr_exp[g] = 0;
    end
    if (b) busy_len[g]++;
    if (en) begin
      if (ad != 8'(addr_exp[g])) addr_bad[g]++;
      addr_exp[g]++;
    end
    if (d && !prev_done[g]) begin
      qsz = (g == 0) ? exp_q0.size() : exp_q1.size();
      check({tag, " pending_sweep"}, int'(qsz > 0), 1);
      if (qsz > 0) begin
        e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check({tag, " busy_len"}, int'(busy_len[g]), 256 + lat_cfg[g]);
        check({tag, " read_cycles"}, int'(addr_exp[g]), 256);
        check({tag, " addr_order_errs"}, int'(addr_bad[g]), 0);
        check({tag, " done_on_busy_fall"}, int'({prev_busy[g], b}), 2);
        check({tag, " pass"}, int'(p), int'(e[17]));
        if (e[18]) begin
          check({tag, " err_cnt"}, int'(ec), int'(e[16:8]));
          check({tag, " first_err_addr"}, int'(fa), int'(e[7:0]));
        end
      end
    end
    prev_busy[g] = b;
    prev_done[g] = d;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    mon_step(0, busy0, done0, bus0.rd_en, bus0.rd_addr, pass0, err_cnt0, first0);
    mon_step(1, busy1, done1, bus1.rd_en, bus1.rd_addr, pass1, {5'b0, err_cnt1}, first1);
  end

  // ---------------- driver tasks ----------------
  task automatic fill_clean();
    for (int a = 0; a < 256; a++) begin
      mem[0][a] = 8'(a);
      mem[1][a] = 8'(a + 16);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_addr(input logic [7:0] a);
    int n;
    n = 0;
    while (!(bus0.rd_en && bus0.rd_addr == a) && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_addr_in_time", int'(n < 600), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " rd_addr0"}, int'(bus0.rd_addr), 0);
    check({tag, " rd_en0"}, int'(bus0.rd_en), 0);
    check({tag, " busy0"}, int'(busy0), 0);
    check({tag, " done0"}, int'(done0), 0);
    check({tag, " pass0"}, int'(pass0), 0);
    check({tag, " err_cnt0"}, int'(err_cnt0), 0);
    check({tag, " first0"}, int'(first0), 0);
    check({tag, " rd_addr1"}, int'(bus1.rd_addr), 0);
    check({tag, " busy1"}, int'(busy1), 0);
    check({tag, " done1"}, int'(done1), 0);
    check({tag, " err_cnt1"}, int'(err_cnt1), 0);
    check({tag, " first1"}, int'(first1), 0);
  endtask

  task automatic do_sweep(input bit poke);
    int n;
    push_expect();
    pulse_start();
    check("busy0_after_start", int'(busy0), 1);
    check("done0_after_start", int'(done0), 0);
    check("busy1_after_start", int'(busy1), 1);
    check("done1_after_start", int'(done1), 0);
    check("rd_addr0_first", int'(bus0.rd_addr), 0);
    check("rd_en0_first", int'(bus0.rd_en), 1);
    if (poke) begin
      wait_addr(8'h10);
      pulse_start();
      wait_addr(8'h80);
      pulse_start();
    end
    n = 0;
    while (!(done0 && done1) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("sweep_done_in_time", int'(n < 1000), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, dones;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    start      = 1'b0;
    ram_dly[0] = 1;
    ram_dly[1] = 2;
    lat_cfg[0] = 1;
    lat_cfg[1] = 2;
    fill_clean();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst = 1'b0;

    // clean fill
    fill_clean();
    do_sweep(1'b0);

    // one corrupted word
    fill_clean();
    mem[0][8'h5A] = 8'h00;
    mem[1][8'h5A] = 8'h00;
    do_sweep(1'b0);

    // q stuck at 0xFF: heavy mismatch, saturation on the narrow counter
    for (int a = 0; a < 256; a++) begin
      mem[0][a] = 8'hFF;
      mem[1][a] = 8'hFF;
    end
    do_sweep(1'b0);

    // random sparse corruption
    for (int r = 0; r < 4; r++) begin
      fill_clean();
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) begin
        mem[0][$urandom_range(0, 255)] = 8'($urandom);
        mem[1][$urandom_range(0, 255)] = 8'($urandom);
      end
      do_sweep(1'b0);
    end

    // 2-cycle RAM behind the RD_LAT=1 checker must fail
    fill_clean();
    ram_dly[0] = 2;
    do_sweep(1'b0);
    ram_dly[0] = 1;

    // start pulses mid-sweep are ignored
    fill_clean();
    mem[0][$urandom_range(0, 255)] = 8'($urandom_range(0, 127) * 2 + 1);
    mem[1][8'h33] = 8'h00;
    do_sweep(1'b1);

    // reset mid-sweep aborts without done
    fill_clean();
    push_expect();
    pulse_start();
    wait_addr(8'h40);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("abort");
    dones = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (done0 || done1) dones++;
    end
    check("no_done_after_abort", dones, 0);
    do_sweep(1'b0);

    @(posedge clk); #1;
    check("exp_q0_drained", exp_q0.size(), 0);
    check("exp_q1_drained", exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_readback_checker.md
# ram_readback_checker

Sweeps the RAM read port after the address/data generator has filled it, comparing every word in `q` against the expected fill pattern. It sits directly downstream of the RAM: it drives the read address and consumes `q`. It reports pass/fail, a saturating mismatch count and the first failing address. The generator and checker share the RAM address bus through the top-level mux; the checker owns the bus only while `busy` is high.

## Interface
- `ADDR_W`, 8, RAM address width; sweep covers 0 .. 2^ADDR_W-1
- `DATA_W`, 8, RAM data width
- `RD_LAT`, 1, RAM read latency in cycles from `rd_addr` to `q` (legal: 1 or 2)
- `OFFSET`, 8'h00, expected pattern: `exp(a) = (a + OFFSET) mod 2^DATA_W`
- `CNT_W`, 9, width of `err_cnt`; count saturates at 2^CNT_W-1
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a sweep when idle or done
- `q`  in  DATA_W  RAM read data
- `rd_addr`  out  ADDR_W  RAM read address
- `rd_en`  out  1  high while `rd_addr` carries a valid read; top level forces `wren` low when this is high
- `busy`  out  1  sweep or pipeline drain in progress
- `done`  out  1  sweep finished; held until the next `start` or `rst`
- `pass`  out  1  valid when `done`; 1 iff `err_cnt == 0`
- `err_cnt`  out  CNT_W  mismatches in the current or last sweep
- `first_err_addr`  out  ADDR_W  address of the first mismatch; 0 if none

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: `start` → READ. On the same edge, clear `err_cnt`, `first_err_addr`, `done`, `pass`, and the internal first-error flag, and load `rd_addr` = 0.
- READ: `rd_en`=1. `rd_addr` increments every cycle. When `rd_addr` = 2^ADDR_W-1 is issued → DRAIN on the next edge.
- DRAIN: `rd_en`=0. `rd_addr` holds its last value. Stays RD_LAT cycles so the in-flight reads can be compared → DONE.
- DONE: `done`=1, `pass` = (`err_cnt`==0). `start` → READ, with the same clearing as from IDLE.
- `start` in READ or DRAIN is ignored, with no effect on count or addresses.
- Compare pipeline: a shift register of depth RD_LAT carries {valid, addr}. The expected value is computed from the delayed address, and `q` is compared when the delayed valid bit is set.
- On a mismatch:
  - `err_cnt` += 1, saturating at 2^CNT_W-1.
  - If the first-error flag is clear, capture the address into `first_err_addr` and set the flag.
- Expected-value addition wraps mod 2^DATA_W. Address counter does not wrap past the top address; the FSM leaves READ first.
- `rst` in any state, including mid-sweep:
  - Next state IDLE; all outputs at reset values.
  - Compare pipeline valid bits cleared.
  - No `done` is produced for the aborted sweep.

## Timing
- Reset values: `rd_addr`=0, `rd_en`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_err_addr`=0.
- Edge E0 samples `start`. From the cycle after E0:
  - `rd_addr`=0 and `rd_en`=1, with `busy`=1.
  - Address a is on the bus during cycle a+1 after E0.
- `q` for an address issued in cycle c is compared at the end of cycle c+RD_LAT. The resulting `err_cnt` and `first_err_addr` are visible the following cycle.
- `busy` is high for exactly 2^ADDR_W + RD_LAT cycles. `done` rises on the cycle `busy` falls, and `err_cnt` is final by then.
- `start` and `rst` in the same cycle: `rst` wins.
- `start` in DONE: `done` drops the following cycle, together with `busy` rising.

## Test plan
- Defaults, RAM filled with data = addr, single `start` → `rd_addr` 0x00..0xFF on consecutive cycles, `busy` high for 257 cycles, then `done`=1, `pass`=1, `err_cnt`=0, `first_err_addr`=0x00.
- Same, but word 0x5A corrupted to 0x00 → `err_cnt`=1, `first_err_addr`=0x5A, `pass`=0.
- Model forces `q`=0xFF always → `err_cnt`=255 (only address 0xFF matches), `first_err_addr`=0x00; with `CNT_W`=4, `err_cnt` saturates at 15.
- `RD_LAT`=2, `OFFSET`=8'h10, RAM filled with addr+0x10, and a RAM model with a 2-cycle delay → `pass`=1, `busy` high for 258 cycles; the same setup with `RD_LAT`=1 fails.
- `rst` asserted for one cycle while `rd_addr`=0x40 → all outputs at reset values the next cycle, no `done`. A subsequent `start` completes a full clean sweep with `pass`=1.
- `start` pulsed at addresses 0x10 and 0x80 of a running sweep → ignored: the sweep completes once, with the same `err_cnt` as an undisturbed run. A `start` in DONE restarts the sweep, with `err_cnt` cleared.
